// File: rtl/p_r_pkg.sv
// p_r_pkg: shared definitions for the P-R register-unit access sequencer.
//   State encodings, the flag-register number and the conversion from a
//   register number to the active-low {rc_, rb_, ra_} address lines.
package p_r_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_SAMPLE = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        SETUP  = ST_SETUP,
        STROBE = ST_STROBE,
        HOLD   = ST_HOLD,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_t;

    // R0 holds the flags; its address pattern (all lines high) doubles as
    // the idle address.
    localparam logic [2:0] REG_R0 = 3'd0;

    // Register n is selected by {~rc_, ~rb_, ~ra_} == n.
    function automatic logic [2:0] reg_to_addr(input logic [2:0] r);
        return ~r;
    endfunction

endpackage

// File: rtl/p_r_arb.sv
// p_r_arb: two-way arbiter between the CPU microsequence and the control panel.
//   Ports:
//     clk_sys, rst_     system clock, asynchronous active-low reset
//     cpu_req, fp_req   request levels
//     fp_en             control-panel requests are eligible only when 1
//     upd, upd_fp       pulse at the end of an access; upd_fp = panel was served
//     gnt_cpu, gnt_fp   combinational one-hot (or zero) grant
//   With FP_FAIR=1 a tie goes to the side not served last; with FP_FAIR=0
//   the CPU always wins a tie.
module p_r_arb
    import p_r_pkg::*;
#(
    parameter bit FP_FAIR = 1'b1
) (
    input  logic clk_sys,
    input  logic rst_,
    input  logic cpu_req,
    input  logic fp_req,
    input  logic fp_en,
    input  logic upd,
    input  logic upd_fp,
    output logic gnt_cpu,
    output logic gnt_fp
);

    // 1 = the panel has priority on the next tie; the CPU starts with it.
    logic prio_fp;

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_)
            prio_fp <= 1'b0;
        else if (upd)
            prio_fp <= ~upd_fp;
    end

    always_comb begin
        gnt_fp  = fp_req & fp_en & (~cpu_req | (FP_FAIR & prio_fp));
        gnt_cpu = cpu_req & ~gnt_fp;
    end

endmodule

// File: rtl/p_r_seq.sv
// p_r_seq: access sequencer for the P-R register unit (R0 flags, R1-R7).
//   Ports:
//     clk_sys, rst_                       system clock, async active-low reset
//     cpu_req/we/reg/wdata, cpu_ack       CPU requester, ack is a 1-cycle pulse
//     fp_req/we/reg/wdata, fp_ack, fp_en  control-panel requester, gated by fp_en
//     rdata                               read data, valid with ack, held
//     w                                   W bus toward P-R
//     l                                   L bus from P-R
//     ra_, rb_, rc_                       active-low register address
//     w_r_                                active-low write qualifier
//     as2                                 strobe pair select (0: strob1_, 1: strob2_)
//     strob1_, strob2_                    active-low strobes
//     rd_en                               L-bus read enable
//     busy                                access in progress
//   Every P-R control output is a flop loaded from next-state values, so the
//   strobes and address lines cannot glitch.
module p_r_seq
    import p_r_pkg::*;
#(
    parameter int STROBE_LEN = 1,
    parameter bit FP_FAIR    = 1'b1
) (
    input  logic        clk_sys,
    input  logic        rst_,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_reg,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        fp_req,
    input  logic        fp_we,
    input  logic [2:0]  fp_reg,
    input  logic [15:0] fp_wdata,
    output logic        fp_ack,
    input  logic        fp_en,
    output logic [15:0] rdata,
    output logic [15:0] w,
    input  logic [15:0] l,
    output logic        ra_,
    output logic        rb_,
    output logic        rc_,
    output logic        w_r_,
    output logic        as2,
    output logic        strob1_,
    output logic        strob2_,
    output logic        rd_en,
    output logic        busy
);

    if (STROBE_LEN < 1 || STROBE_LEN > 4) begin : g_bad_strobe_len
        $error("p_r_seq: STROBE_LEN must be in 1..4");
    end

    localparam logic [1:0] CNT_INIT = 2'(STROBE_LEN - 1);

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic        lat_we, we_n;
    logic        lat_fp, fp_n;
    logic [2:0]  lat_reg, reg_n;
    logic [15:0] lat_wd, wd_n;
    logic        par, par_n;
    logic        gnt_cpu, gnt_fp, upd;
    logic        act, wr;
    logic [2:0]  addr_nx;
    logic [15:0] w_nx;
    logic        w_r_nx, as2_nx, strob1_nx, strob2_nx, rd_en_nx;
    logic        cpu_ack_nx, fp_ack_nx, busy_nx;

    p_r_arb #(.FP_FAIR(FP_FAIR)) u_arb (
        .clk_sys (clk_sys),
        .rst_    (rst_),
        .cpu_req (cpu_req),
        .fp_req  (fp_req),
        .fp_en   (fp_en),
        .upd     (upd),
        .upd_fp  (lat_fp),
        .gnt_cpu (gnt_cpu),
        .gnt_fp  (gnt_fp)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        we_n    = lat_we;
        fp_n    = lat_fp;
        reg_n   = lat_reg;
        wd_n    = lat_wd;
        par_n   = par;
        upd     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_cpu || gnt_fp) begin
                    state_n = SETUP;
                    fp_n    = gnt_fp;
                    we_n    = gnt_fp ? fp_we    : cpu_we;
                    reg_n   = gnt_fp ? fp_reg   : cpu_reg;
                    wd_n    = gnt_fp ? fp_wdata : cpu_wdata;
                end
            end
            SETUP: begin
                state_n = lat_we ? STROBE : SAMPLE;
                cnt_n   = CNT_INIT;
            end
            STROBE: begin
                state_n = (cnt == 2'd0) ? HOLD : STROBE;
                cnt_n   = cnt - 2'd1;
            end
            HOLD:    state_n = DONE;
            SAMPLE:  state_n = DONE;
            DONE: begin
                state_n = IDLE;
                upd     = 1'b1;
                // Successive writes alternate between the two strobe pairs.
                par_n   = par ^ lat_we;
            end
            default: state_n = IDLE;
        endcase
        // Output flops are loaded with the values for the state being entered.
        act        = (state_n == SETUP) || (state_n == STROBE) ||
                     (state_n == HOLD)  || (state_n == SAMPLE);
        wr         = act & we_n;
        addr_nx    = act ? reg_to_addr(reg_n) : reg_to_addr(REG_R0);
        w_nx       = wr ? wd_n : 16'h0000;
        w_r_nx     = ~wr;
        as2_nx     = wr & par_n;
        strob1_nx  = ~((state_n == STROBE) & ~par_n);
        strob2_nx  = ~((state_n == STROBE) & par_n);
        rd_en_nx   = act & ~we_n;
        cpu_ack_nx = (state_n == DONE) & ~fp_n;
        fp_ack_nx  = (state_n == DONE) & fp_n;
        busy_nx    = state_n != IDLE;
    end

    always_ff @(posedge clk_sys or negedge rst_) begin
        if (!rst_) begin
            state           <= IDLE;
            cnt             <= 2'd0;
            lat_we          <= 1'b0;
            lat_fp          <= 1'b0;
            lat_reg         <= 3'd0;
            lat_wd          <= 16'h0000;
            par             <= 1'b0;
            {rc_, rb_, ra_} <= reg_to_addr(REG_R0);
            w               <= 16'h0000;
            w_r_            <= 1'b1;
            as2             <= 1'b0;
            strob1_         <= 1'b1;
            strob2_         <= 1'b1;
            rd_en           <= 1'b0;
            cpu_ack         <= 1'b0;
            fp_ack          <= 1'b0;
            busy            <= 1'b0;
            rdata           <= 16'h0000;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            lat_we          <= we_n;
            lat_fp          <= fp_n;
            lat_reg         <= reg_n;
            lat_wd          <= wd_n;
            par             <= par_n;
            {rc_, rb_, ra_} <= addr_nx;
            w               <= w_nx;
            w_r_            <= w_r_nx;
            as2             <= as2_nx;
            strob1_         <= strob1_nx;
            strob2_         <= strob2_nx;
            rd_en           <= rd_en_nx;
            cpu_ack         <= cpu_ack_nx;
            fp_ack          <= fp_ack_nx;
            busy            <= busy_nx;
            rdata           <= (state == SAMPLE) ? l : rdata;
        end
    end

endmodule
